// File: rtl/pc_sequencer.sv
// Program-counter sequencer: owns the instruction address, runs one program
// from address 0 until halt, and keeps cycle / taken-branch counters.
module pc_sequencer #(
  parameter int D  = 12,
  parameter int CW = 16,
  parameter int BW = 8
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          start,
  input  logic          stall,
  input  logic          branch_en,
  input  logic [D-1:0]  target,
  input  logic          halt,
  output logic [D-1:0]  prog_ctr,
  output logic          running,
  output logic          done,
  output logic [CW-1:0] cycle_count,
  output logic [BW-1:0] branch_count
);

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    RUN    = 2'b01,
    HALTED = 2'b10,
    UNUSED = 2'b11
  } state_t;

  state_t state;

  // Status flags are pure decodes of the state register.
  assign running = (state == RUN);
  assign done    = (state == HALTED);

  // Sequencer state, program counter and performance counters.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state        <= IDLE;
      prog_ctr     <= '0;
      cycle_count  <= '0;
      branch_count <= '0;
    end else begin
      case (state)
        IDLE: begin
          prog_ctr <= '0;
          if (start) begin
            state        <= RUN;
            cycle_count  <= '0;
            branch_count <= '0;
          end
        end

        RUN: begin
          if (cycle_count != '1)
            cycle_count <= cycle_count + 1'b1;
          if (halt) begin
            state <= HALTED;
          end else if (stall) begin
            prog_ctr <= prog_ctr;
          end else if (branch_en) begin
            // D-bit add of a two's-complement offset; carry is dropped.
            prog_ctr <= prog_ctr + target;
            if (branch_count != '1)
              branch_count <= branch_count + 1'b1;
          end else begin
            prog_ctr <= prog_ctr + 1'b1;
          end
        end

        HALTED: begin
          if (start) begin
            state        <= RUN;
            prog_ctr     <= '0;
            cycle_count  <= '0;
            branch_count <= '0;
          end
        end

        default: begin
          state    <= IDLE;
          prog_ctr <= '0;
        end
      endcase
    end
  end

endmodule
